serial_sub_nand: RTL and testbench

Bit-serial subtractor computing `diff = a - b - bin` over `WIDTH` bits, one bit per clock, LSB first. The per-bit arithmetic is a full-subtractor cell built only from 2-input NAND primitives, the subtract-side counterpart of the NAND full adder in the same library. The block sits beside the NAND adder/subtractor cells as the area-minimal sequential datapath: one cell is reused `WIDTH` times under a small FSM with a start/done handshake.

---
 rtl/nand_arith_pkg.sv | 14 +
 rtl/fs_nand.sv | 27 ++
 rtl/serial_sub_nand.sv | 99 +++++++++
 tb/tb_serial_sub_nand.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/nand_arith_pkg.sv
// Shared definitions for the NAND-based arithmetic cells: sequencer states
// and the legal operand-width range of the serial datapaths.
package nand_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_e;

    localparam int SUB_WIDTH_MIN = 2;
    localparam int SUB_WIDTH_MAX = 32;

endpackage

// File: rtl/fs_nand.sv
// One-bit full subtractor (d = x - y - bi) built from nine 2-input NAND gates.
module fs_nand (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    logic n1, n2, n3, p;
    logic m1, m2, m3;

    // p = x ^ y; n3 doubles as ~(~x & y) for the borrow path.
    nand g_n1 (n1, x, y);
    nand g_n2 (n2, x, n1);
    nand g_n3 (n3, y, n1);
    nand g_p  (p, n2, n3);

    // d = p ^ bi; m3 doubles as ~(~p & bi).
    nand g_m1 (m1, p, bi);
    nand g_m2 (m2, p, m1);
    nand g_m3 (m3, bi, m1);
    nand g_d  (d, m2, m3);

    nand g_bo (bo, n3, m3);

endmodule

// File: rtl/serial_sub_nand.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one fs_nand cell
// reused WIDTH times under an IDLE/SHIFT/DONE sequencer.
module serial_sub_nand
    import nand_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // Handshake: start is accepted on any edge where busy=0 (IDLE or DONE);
    // a, b and bin are captured on that edge. done pulses for one cycle with
    // busy=0 once diff/bout are valid; they then hold until the next accept.

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_e       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] r_next;

    fs_nand u_cell (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .bi (brw),
        .d  (cell_d),
        .bo (cell_bo)
    );

    assign r_next = {cell_d, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        brw   <= bin;
                        r_sr  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_sr <= r_next;
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    brw  <= cell_bo;
                    cnt  <= cnt + CW'(1);
                    // Outputs are published only once the last bit is in.
                    if (cnt == LAST) begin
                        diff  <= r_next;
                        bout  <= cell_bo;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_nand.sv
// Self-checking bench for serial_sub_nand (WIDTH=8) and its fs_nand cell.
module tb_serial_sub_nand;
    import nand_arith_pkg::*;

    localparam int W = 8;
    localparam int MAX_WAIT = 20;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         bin_i;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    logic cx, cy, cbi, cd, cbo;

    int checks = 0;
    int failures = 0;
    logic [W:0] exp_q[$];
    vec_t vecs[12];

    serial_sub_nand #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .bin   (bin_i),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    fs_nand u_cell (
        .x  (cx),
        .y  (cy),
        .bi (cbi),
        .d  (cd),
        .bo (cbo)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks: called at a falling edge, return at the falling edge after E0.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        a_i   = av;
        b_i   = bv;
        bin_i = bi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit seen);
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < MAX_WAIT) begin
            @(negedge clk);
            cyc++;
            chk("busy_done_excl", 32'(busy & done), 32'd0);
            if (done) seen = 1'b1;
            else chk("busy_in_shift", 32'(busy), 32'd1);
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                          input logic [W:0] exp, input string tag);
        int cyc;
        bit seen;
        logic [W:0] want;
        exp_q.push_back(exp);
        launch(av, bv, bi);
        wait_done(cyc, seen);
        want = exp_q.pop_front();
        chk({tag, "_latency"}, 32'(cyc), 32'd9);
        if (seen) chk({tag, "_result"}, 32'({bout, diff}), 32'(want));
        @(negedge clk);
        chk({tag, "_done_width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc;
        bit seen;
        int pulses;
        int first;
        int t;

        vecs[0]  = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        vecs[1]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3]  = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
        vecs[4]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
        vecs[5]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        vecs[6]  = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
        vecs[7]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[8]  = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[9]  = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};
        vecs[10] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0};
        vecs[11] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
        bin_i = 1'b0;

        // Exhaustive cell check against integer subtraction.
        for (int i = 0; i < 8; i++) begin
            cx  = i[2];
            cy  = i[1];
            cbi = i[0];
            #1;
            t = int'(cx) - int'(cy) - int'(cbi);
            chk($sformatf("fs_d_%0d", i), 32'(cd), 32'(t & 1));
            chk($sformatf("fs_bo_%0d", i), 32'(cbo), 32'(t < 0));
        end

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, {vecs[i].bo, vecs[i].d},
                   $sformatf("vec%0d", i));

        // start during SHIFT must be ignored.
        launch(8'h10, 8'h01, 1'b0);
        cyc = 1;
        pulses = 0;
        first = 0;
        for (int k = 0; k < 13; k++) begin
            if (cyc == 4) begin
                a_i   = 8'hAA;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (done) begin
                pulses++;
                if (first == 0) first = cyc;
            end
        end
        chk("ign_pulses", 32'(pulses), 32'd1);
        chk("ign_latency", 32'(first), 32'd9);
        chk("ign_diff", 32'(diff), 32'h0F);
        chk("ign_bout", 32'(bout), 32'd0);

        // Reset while bit 4 is in the cell.
        launch(8'h5A, 8'h3C, 1'b0);
        cyc = 1;
        while (cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        chk("mid_rst_bout", 32'(bout), 32'd0);
        chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("mid_rst_no_done", 32'(pulses), 32'd0);
        run_op(8'h80, 8'h01, 1'b0, {1'b0, 8'h7F}, "post_rst");

        // Back-to-back: second start held in the first DONE cycle.
        launch(8'h05, 8'h03, 1'b0);
        wait_done(cyc, seen);
        chk("b2b1_latency", 32'(cyc), 32'd9);
        chk("b2b1_diff", 32'(diff), 32'h02);
        chk("b2b1_bout", 32'(bout), 32'd0);
        launch(8'h03, 8'h05, 1'b0);
        chk("b2b_done_drop", 32'(done), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done(cyc, seen);
        chk("b2b2_latency", 32'(cyc), 32'd9);
        chk("b2b2_diff", 32'(diff), 32'hFE);
        chk("b2b2_bout", 32'(bout), 32'd1);
        @(negedge clk);

        // Random sweep against integer subtraction.
        for (int i = 0; i < 500; i++) begin
            logic [W-1:0] ra, rb;
            logic rbi;
            ra  = W'($urandom_range(0, 255));
            rb  = W'($urandom_range(0, 255));
            rbi = 1'($urandom_range(0, 1));
            t = int'(ra) - int'(rb) - int'(rbi);
            run_op(ra, rb, rbi, {t < 0, t[W-1:0]}, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
